wishbone_master_arbiter: RTL

- Two-master, one-slave Wishbone classic arbiter that shares the single user-project bus feeding the peripheral address decoder.
- Requesters are master 0 (management SoC port) and master 1 (internal DMA/sequencer).
- Uses round-robin arbitration. The grant is held for the whole cycle, i.e. while the owner keeps cyc high.
- A watchdog terminates slave transactions that are never acknowledged, so a hung peripheral cannot lock the bus.

---
 rtl/wishbone_master_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wishbone_master_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter with round-robin ownership
// and a watchdog that force-terminates strobes a slave never acknowledges.
module wishbone_master_arbiter #(
  parameter int                        ADDR_WIDTH   = 32,
  parameter int                        DATA_WIDTH   = 32,
  parameter int                        SEL_WIDTH    = DATA_WIDTH / 8,
  parameter int                        TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0]     TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_wb_adr,
  input  logic [DATA_WIDTH-1:0] m0_wb_dat_w,
  output logic [DATA_WIDTH-1:0] m0_wb_dat_r,
  input  logic                  m0_wb_we,
  input  logic [SEL_WIDTH-1:0]  m0_wb_sel,
  input  logic                  m0_wb_cyc,
  input  logic                  m0_wb_stb,
  output logic                  m0_wb_ack,
  input  logic [ADDR_WIDTH-1:0] m1_wb_adr,
  input  logic [DATA_WIDTH-1:0] m1_wb_dat_w,
  output logic [DATA_WIDTH-1:0] m1_wb_dat_r,
  input  logic                  m1_wb_we,
  input  logic [SEL_WIDTH-1:0]  m1_wb_sel,
  input  logic                  m1_wb_cyc,
  input  logic                  m1_wb_stb,
  output logic                  m1_wb_ack,
  output logic [ADDR_WIDTH-1:0] s_wb_adr,
  output logic [DATA_WIDTH-1:0] s_wb_dat_w,
  output logic                  s_wb_we,
  output logic [SEL_WIDTH-1:0]  s_wb_sel,
  output logic                  s_wb_cyc,
  output logic                  s_wb_stb,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_r,
  input  logic                  s_wb_ack,
  output logic [1:0]            grant,
  output logic                  timeout_flag,
  input  logic                  timeout_clr
);

  localparam int              CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

  owner_t           owner_reg, owner_next;
  logic             last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             timeout_flag_reg, timeout_flag_next;

  logic [ADDR_WIDTH-1:0] a_adr;
  logic [DATA_WIDTH-1:0] a_dat_w;
  logic                  a_we, a_cyc, a_stb;
  logic [SEL_WIDTH-1:0]  a_sel;
  logic                  wd_expired, timeout_hit;
  logic [1:0]            m_ack;
  logic [DATA_WIDTH-1:0] m_dat_r [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg        <= IDLE;
      last_owner_reg   <= 1'b1;
      wd_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      owner_reg        <= owner_next;
      last_owner_reg   <= last_owner_next;
      wd_cnt_reg       <= wd_cnt_next;
      timeout_flag_reg <= timeout_flag_next;
    end
  end

  // Owner's request lines; everything reads as zero while idle.
  always_comb begin
    a_adr   = '0;
    a_dat_w = '0;
    a_we    = 1'b0;
    a_sel   = '0;
    a_cyc   = 1'b0;
    a_stb   = 1'b0;
    case (owner_reg)
      OWN0: begin
        a_adr   = m0_wb_adr;
        a_dat_w = m0_wb_dat_w;
        a_we    = m0_wb_we;
        a_sel   = m0_wb_sel;
        a_cyc   = m0_wb_cyc;
        a_stb   = m0_wb_stb;
      end
      OWN1: begin
        a_adr   = m1_wb_adr;
        a_dat_w = m1_wb_dat_w;
        a_we    = m1_wb_we;
        a_sel   = m1_wb_sel;
        a_cyc   = m1_wb_cyc;
        a_stb   = m1_wb_stb;
      end
      default: ;
    endcase
  end

  // A real slave ack in the expiry cycle wins over the forced termination.
  assign wd_expired  = (wd_cnt_reg == TIMEOUT_CNT);
  assign timeout_hit = a_cyc & a_stb & wd_expired & ~s_wb_ack;

  assign s_wb_adr   = a_adr;
  assign s_wb_dat_w = a_dat_w;
  assign s_wb_we    = a_we;
  assign s_wb_sel   = a_sel;
  assign s_wb_cyc   = a_cyc;
  assign s_wb_stb   = a_stb & ~wd_expired;

  assign grant        = {owner_reg == OWN1, owner_reg == OWN0};
  assign timeout_flag = timeout_flag_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master_resp
    assign m_ack[gi]   = grant[gi] & (s_wb_ack | timeout_hit);
    assign m_dat_r[gi] = grant[gi] ? (timeout_hit ? TIMEOUT_DATA : s_wb_dat_r) : '0;
  end

  assign m0_wb_ack   = m_ack[0];
  assign m1_wb_ack   = m_ack[1];
  assign m0_wb_dat_r = m_dat_r[0];
  assign m1_wb_dat_r = m_dat_r[1];

  always_comb begin
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    case (owner_reg)
      IDLE: begin
        if (m0_wb_cyc && m1_wb_cyc) owner_next = last_owner_reg ? OWN0 : OWN1;
        else if (m0_wb_cyc)         owner_next = OWN0;
        else if (m1_wb_cyc)         owner_next = OWN1;
      end
      OWN0: begin
        if (!m0_wb_cyc) begin
          owner_next      = IDLE;
          last_owner_next = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_wb_cyc) begin
          owner_next      = IDLE;
          last_owner_next = 1'b1;
        end
      end
      default: owner_next = IDLE;
    endcase
  end

  // Stb is already forced low in the expiry cycle, so the counter clears then too.
  always_comb begin
    wd_cnt_next = '0;
    if (owner_next == owner_reg && s_wb_cyc && s_wb_stb && !s_wb_ack)
      wd_cnt_next = wd_cnt_reg + CNT_W'(1);
  end

  always_comb begin
    timeout_flag_next = timeout_flag_reg;
    if (timeout_hit)      timeout_flag_next = 1'b1;
    else if (timeout_clr) timeout_flag_next = 1'b0;
  end

endmodule
